array_burst_reader: RTL and testbench

- Read-side engine for the 16-entry, 8-bit register array that the write-side logic fills at an incrementing pointer.
- On a start command, it reads burst_len consecutive entries from base_addr, wrapping modulo array depth, through a 1-cycle-latency memory read port.
- It presents the words as a valid/ready stream with last-word marking.
- A 2-entry output buffer absorbs the read latency and downstream back-pressure without losing or duplicating words.

---
 rtl/array_burst_reader_if.sv | 31 +++
 rtl/array_burst_reader.sv | 161 ++++++++++++++++
 tb/tb_array_burst_reader.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/array_burst_reader_if.sv
// Stream, control and array-read signals of the burst reader.
// slave is the reader side, master the controller/array/sink side.
interface array_burst_reader_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned LEN_W  = 5
) ();
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [LEN_W-1:0]  burst_len;
   logic              busy;
   logic              done;
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_rd_addr;
   logic [DATA_W-1:0] mem_rd_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_last;
   logic [LEN_W-1:0]  words_sent;

   modport slave (
      input  start, base_addr, burst_len, mem_rd_data, out_ready,
      output busy, done, mem_rd_en, mem_rd_addr, out_valid, out_data, out_last, words_sent
   );

   modport master (
      output start, base_addr, burst_len, mem_rd_data, out_ready,
      input  busy, done, mem_rd_en, mem_rd_addr, out_valid, out_data, out_last, words_sent
   );
endinterface

// File: rtl/array_burst_reader.sv
// Reads a burst of consecutive (wrapping) array entries through a 1-cycle read port
// and streams them out via a 2-entry buffer with valid/ready and last-word marking.
module array_burst_reader #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned LEN_W  = 5
) (
   input logic                 clk,
   input logic                 rst,
   array_burst_reader_if.slave bus
);
   localparam int unsigned      Depth    = 2 ** ADDR_W;
   localparam logic [LEN_W-1:0] DepthLen = LEN_W'(Depth);

   typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

   state_e                     state_q, state_d;
   logic [ADDR_W-1:0]          rd_addr_q, rd_addr_d;
   logic [LEN_W-1:0]           len_q, len_d;
   logic [LEN_W-1:0]           issued_q, issued_d;
   logic [LEN_W-1:0]           sent_q, sent_d;
   logic                       inflight_q;
   logic [1:0][DATA_W-1:0]     fifo_q, fifo_d;
   logic                       rd_ptr_q, rd_ptr_d;
   logic                       wr_ptr_q, wr_ptr_d;
   logic [1:0]                 occ_q, occ_d;

   logic [LEN_W-1:0] len_eff;
   logic             accept;
   logic             out_valid;
   logic             pop;
   logic             push;
   logic             can_issue;
   logic             rd_en;
   logic             busy;
   logic             done;
   logic             last_issue;
   logic             drained;

   assign len_eff   = (bus.burst_len > DepthLen) ? DepthLen : bus.burst_len;
   assign accept    = (state_q == StIdle) && bus.start;
   assign out_valid = (occ_q != 2'd0);
   assign pop       = out_valid && bus.out_ready;
   assign push      = inflight_q;
   // occ + inflight - pop < 2, rearranged so nothing underflows
   assign can_issue = ({1'b0, occ_q} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop});
   assign last_issue = rd_en && ((issued_q + LEN_W'(1)) == len_q);
   assign drained    = !inflight_q && (occ_q == 2'd0) && (sent_q == len_q);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (bus.start) state_d = (len_eff != '0) ? StRead : StDone;
         end
         StRead: begin
            if (last_issue) state_d = StDrain;
         end
         StDrain: begin
            if (drained) state_d = StDone;
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs
   always_comb begin
      busy  = 1'b0;
      done  = 1'b0;
      rd_en = 1'b0;
      unique case (state_q)
         StIdle: ;
         StRead: begin
            busy  = 1'b1;
            rd_en = can_issue;
         end
         StDrain: busy = 1'b1;
         StDone: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: ;
      endcase
   end

   // Datapath next-state: read pointer, counters and output buffer
   always_comb begin
      rd_addr_d = rd_addr_q;
      len_d     = len_q;
      issued_d  = issued_q;
      sent_d    = sent_q;
      fifo_d    = fifo_q;
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      occ_d     = occ_q + {1'b0, push} - {1'b0, pop};

      if (accept) begin
         rd_addr_d = bus.base_addr;
         len_d     = len_eff;
         issued_d  = '0;
         sent_d    = '0;
      end else begin
         if (rd_en) begin
            rd_addr_d = rd_addr_q + ADDR_W'(1);
            issued_d  = issued_q + LEN_W'(1);
         end
         if (pop) sent_d = sent_q + LEN_W'(1);
      end

      if (push) begin
         fifo_d[wr_ptr_q] = bus.mem_rd_data;
         wr_ptr_d         = ~wr_ptr_q;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_addr_q  <= '0;
         len_q      <= '0;
         issued_q   <= '0;
         sent_q     <= '0;
         inflight_q <= 1'b0;
         fifo_q     <= '0;
         rd_ptr_q   <= 1'b0;
         wr_ptr_q   <= 1'b0;
         occ_q      <= '0;
      end else begin
         rd_addr_q  <= rd_addr_d;
         len_q      <= len_d;
         issued_q   <= issued_d;
         sent_q     <= sent_d;
         inflight_q <= rd_en;
         fifo_q     <= fifo_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         occ_q      <= occ_d;
      end
   end

   assign bus.busy        = busy;
   assign bus.done        = done;
   assign bus.mem_rd_en   = rd_en;
   assign bus.mem_rd_addr = rd_addr_q;
   assign bus.out_valid   = out_valid;
   assign bus.out_data    = fifo_q[rd_ptr_q];
   // Head word is word sent_q+1 of the burst
   assign bus.out_last    = out_valid && ((sent_q + LEN_W'(1)) == len_q);
   assign bus.words_sent  = sent_q;
endmodule

// File: tb/tb_array_burst_reader.sv
// Directed bench for array_burst_reader: array model with 1-cycle read latency,
// per-cycle recorder of handshakes/reads, one task per scenario.
module tb_array_burst_reader;
   logic clk = 1'b0;
   logic rst = 1'b0;

   array_burst_reader_if bus ();

   array_burst_reader dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [16];
   always_ff @(posedge clk) if (bus.mem_rd_en === 1'b1) bus.mem_rd_data <= mem[bus.mem_rd_addr];

   int errors = 0;
   int checks = 0;

   logic [8:0] rx_q [$];
   logic [3:0] addr_q [$];
   int         done_cnt, stall_err, stall_cyc, ovf_err, rd_cnt, hs_cnt;
   bit         prev_stall, valid_seen, timeout;
   logic [7:0] prev_data;
   logic       prev_last;

   task automatic clear_rec();
      rx_q.delete();
      addr_q.delete();
      done_cnt = 0; stall_err = 0; stall_cyc = 0; ovf_err = 0; rd_cnt = 0; hs_cnt = 0;
      prev_stall = 0; valid_seen = 0;
   endtask

   // Records what happens at the coming clock edge; sampled mid-cycle.
   task automatic observe();
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
         rx_q.push_back({bus.out_last, bus.out_data});
         hs_cnt++;
      end
      if (bus.mem_rd_en === 1'b1) begin
         addr_q.push_back(bus.mem_rd_addr);
         rd_cnt++;
      end
      if (bus.out_valid === 1'b1) valid_seen = 1;
      if (bus.done === 1'b1) done_cnt++;
      if (prev_stall && (bus.out_valid !== 1'b1 || bus.out_data !== prev_data ||
                         bus.out_last !== prev_last)) stall_err++;
      prev_stall = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b0);
      if (prev_stall) stall_cyc++;
      prev_data = bus.out_data;
      prev_last = bus.out_last;
      if (rd_cnt - hs_cnt > 2) ovf_err++;
   endtask

   task automatic next_cycle(input logic rdy, input logic st);
      @(negedge clk);
      bus.out_ready = rdy;
      bus.start     = st;
      #1;
      observe();
   endtask

   task automatic launch(input logic [3:0] b, input logic [4:0] l);
      bus.base_addr = b;
      bus.burst_len = l;
      next_cycle(1'b1, 1'b1);
   endtask

   // mode 0: ready high; 1: ready 1,0,0 repeating; 2: ready high plus a start at cycle 3
   task automatic wait_idle(input int mode, output int n);
      logic rdy, st;
      n = 0;
      timeout = 1;
      for (int c = 1; c <= 200; c++) begin
         rdy = (mode == 1) ? (c % 3 == 1) : 1'b1;
         st  = (mode == 2) && (c == 3);
         if (st) begin
            bus.base_addr = 4'd9;
            bus.burst_len = 5'd2;
         end
         next_cycle(rdy, st);
         if (bus.busy === 1'b0) begin
            n = c;
            timeout = 0;
            break;
         end
      end
   endtask

   function automatic logic [8:0] exp_word(input logic [3:0] b, input int l, input int i);
      logic [3:0] a;
      a = b + 4'(i);
      return {(i == l - 1), mem[a]};
   endfunction

   task automatic test_reset();
      #1 rst = 1'b1;
      #1;
      checks++;
      if ({bus.busy, bus.done, bus.mem_rd_en, bus.mem_rd_addr, bus.out_valid, bus.out_data,
           bus.out_last, bus.words_sent} !== 22'd0) begin
         errors++;
         $display("FAIL reset_outputs: busy=%b done=%b rd_en=%b addr=%h valid=%b data=%h last=%b ws=%0d, required all 0",
                  bus.busy, bus.done, bus.mem_rd_en, bus.mem_rd_addr, bus.out_valid,
                  bus.out_data, bus.out_last, bus.words_sent);
      end
      @(negedge clk);
      rst = 1'b0;
      clear_rec();
      next_cycle(1'b1, 1'b0);
      next_cycle(1'b1, 1'b0);
      checks++;
      if (bus.busy !== 1'b0 || rd_cnt !== 0 || valid_seen !== 0) begin
         errors++;
         $display("FAIL reset_idle: busy=%b reads=%0d valid_seen=%0d, required 0/0/0",
                  bus.busy, rd_cnt, valid_seen);
      end
   endtask

   task automatic test_basic();
      int done_c, fb;
      done_c = -1;
      clear_rec();
      launch(4'd3, 5'd4);
      for (int c = 1; c <= 10; c++) begin
         next_cycle(1'b1, 1'b0);
         if (bus.done === 1'b1 && done_c < 0) done_c = c;
         if (c == 1) begin
            checks++;
            if (bus.mem_rd_en !== 1'b1 || bus.mem_rd_addr !== 4'd3) begin
               errors++;
               $display("FAIL basic_first_read: rd_en=%b addr=%0d, required 1/3",
                        bus.mem_rd_en, bus.mem_rd_addr);
            end
         end
         if (c == 2) begin
            checks++;
            if (bus.out_valid !== 1'b0) begin
               errors++;
               $display("FAIL basic_valid_early: out_valid=%b, required 0", bus.out_valid);
            end
         end
         if (c >= 3 && c <= 6) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 8'(8'hA0 + c) ||
                bus.out_last !== (c == 6)) begin
               errors++;
               $display("FAIL basic_stream c%0d: valid=%b data=%h last=%b, required 1/%h/%b",
                        c, bus.out_valid, bus.out_data, bus.out_last, 8'(8'hA0 + c), (c == 6));
            end
         end
      end
      fb = -1;
      for (int i = 0; i < 4; i++) if (fb < 0 && (i >= addr_q.size() || addr_q[i] !== 4'(3 + i))) fb = i;
      checks++;
      if (fb >= 0 || addr_q.size() != 4) begin
         errors++;
         $display("FAIL basic_addrs: %0d reads, first bad index %0d, required addresses 3,4,5,6",
                  addr_q.size(), fb);
      end
      checks++;
      if (done_cnt !== 1 || done_c !== 8) begin
         errors++;
         $display("FAIL basic_done: pulses=%0d first at c%0d, required 1 at c8", done_cnt, done_c);
      end
      checks++;
      if (bus.words_sent !== 5'd4 || hs_cnt !== 4) begin
         errors++;
         $display("FAIL basic_words_sent: ws=%0d handshakes=%0d, required 4/4",
                  bus.words_sent, hs_cnt);
      end
   endtask

   task automatic test_wrap_clamp();
      int n, fb;
      clear_rec();
      launch(4'd14, 5'd20);
      wait_idle(0, n);
      checks++;
      if (timeout || n != 21) begin
         errors++;
         $display("FAIL wrap_duration: idle after %0d cycles (timeout=%0d), required 21", n, timeout);
      end
      fb = -1;
      for (int i = 0; i < 16; i++)
         if (fb < 0 && (i >= rx_q.size() || rx_q[i] !== exp_word(4'd14, 16, i))) fb = i;
      checks++;
      if (fb >= 0 || rx_q.size() != 16) begin
         errors++;
         $display("FAIL wrap_data: %0d words, first bad index %0d got %h, required 16 words, that word %h",
                  rx_q.size(), fb, (fb >= 0 && fb < rx_q.size()) ? rx_q[fb] : 9'h1ff,
                  exp_word(4'd14, 16, (fb < 0) ? 0 : fb));
      end
      fb = -1;
      for (int i = 0; i < 16; i++) if (fb < 0 && (i >= addr_q.size() || addr_q[i] !== 4'(14 + i))) fb = i;
      checks++;
      if (fb >= 0 || addr_q.size() != 16) begin
         errors++;
         $display("FAIL wrap_addrs: %0d reads, first bad index %0d, required 16 reads from 14 wrapping",
                  addr_q.size(), fb);
      end
      checks++;
      if (bus.words_sent !== 5'd16 || done_cnt !== 1) begin
         errors++;
         $display("FAIL wrap_count: ws=%0d done=%0d, required 16/1", bus.words_sent, done_cnt);
      end
   endtask

   task automatic test_backpressure();
      int n, fb;
      clear_rec();
      launch(4'd5, 5'd6);
      wait_idle(1, n);
      fb = -1;
      for (int i = 0; i < 6; i++)
         if (fb < 0 && (i >= rx_q.size() || rx_q[i] !== exp_word(4'd5, 6, i))) fb = i;
      checks++;
      if (timeout || fb >= 0 || rx_q.size() != 6) begin
         errors++;
         $display("FAIL bp_data: %0d words (timeout=%0d), first bad index %0d, required 6 words from 5",
                  rx_q.size(), timeout, fb);
      end
      checks++;
      if (stall_err !== 0 || stall_cyc == 0) begin
         errors++;
         $display("FAIL bp_stall: unstable=%0d stalled_cycles=%0d, required 0 and >0",
                  stall_err, stall_cyc);
      end
      checks++;
      if (ovf_err !== 0 || rd_cnt !== 6) begin
         errors++;
         $display("FAIL bp_reads: over-issue=%0d reads=%0d, required 0/6", ovf_err, rd_cnt);
      end
      checks++;
      if (bus.words_sent !== 5'd6 || done_cnt !== 1) begin
         errors++;
         $display("FAIL bp_count: ws=%0d done=%0d, required 6/1", bus.words_sent, done_cnt);
      end
   endtask

   task automatic test_zero_len();
      clear_rec();
      launch(4'd7, 5'd0);
      next_cycle(1'b1, 1'b0);
      checks++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b1 || bus.words_sent !== 5'd0) begin
         errors++;
         $display("FAIL zero_done: done=%b busy=%b ws=%0d, required 1/1/0",
                  bus.done, bus.busy, bus.words_sent);
      end
      next_cycle(1'b1, 1'b0);
      next_cycle(1'b1, 1'b0);
      checks++;
      if (bus.busy !== 1'b0 || done_cnt !== 1 || rd_cnt !== 0 || valid_seen !== 0) begin
         errors++;
         $display("FAIL zero_quiet: busy=%b done=%0d reads=%0d valid_seen=%0d, required 0/1/0/0",
                  bus.busy, done_cnt, rd_cnt, valid_seen);
      end
   endtask

   task automatic test_busy_start();
      int n, fb;
      clear_rec();
      launch(4'd0, 5'd5);
      wait_idle(2, n);
      fb = -1;
      for (int i = 0; i < 5; i++)
         if (fb < 0 && (i >= rx_q.size() || rx_q[i] !== exp_word(4'd0, 5, i))) fb = i;
      checks++;
      if (timeout || fb >= 0 || rx_q.size() != 5) begin
         errors++;
         $display("FAIL busy_data: %0d words (timeout=%0d), first bad index %0d, required 5 words from 0",
                  rx_q.size(), timeout, fb);
      end
      for (int c = 0; c < 3; c++) next_cycle(1'b1, 1'b0);
      checks++;
      if (rd_cnt !== 5 || done_cnt !== 1 || bus.busy !== 1'b0 || bus.words_sent !== 5'd5) begin
         errors++;
         $display("FAIL busy_ignored: reads=%0d done=%0d busy=%b ws=%0d, required 5/1/0/5",
                  rd_cnt, done_cnt, bus.busy, bus.words_sent);
      end
   endtask

   task automatic test_reset_mid_burst();
      int n, fb;
      clear_rec();
      launch(4'd8, 5'd8);
      for (int c = 0; c < 20; c++) begin
         next_cycle(1'b1, 1'b0);
         if (hs_cnt >= 2) break;
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (hs_cnt !== 2 || {bus.busy, bus.done, bus.mem_rd_en, bus.mem_rd_addr, bus.out_valid,
                           bus.out_data, bus.out_last, bus.words_sent} !== 22'd0) begin
         errors++;
         $display("FAIL midrst_outputs: hs=%0d busy=%b rd_en=%b addr=%h valid=%b data=%h last=%b ws=%0d, required hs=2 rest 0",
                  hs_cnt, bus.busy, bus.mem_rd_en, bus.mem_rd_addr, bus.out_valid,
                  bus.out_data, bus.out_last, bus.words_sent);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      clear_rec();
      for (int c = 0; c < 5; c++) next_cycle(1'b1, 1'b0);
      checks++;
      if (rd_cnt !== 0 || valid_seen !== 0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL midrst_quiet: reads=%0d valid_seen=%0d busy=%b, required 0/0/0",
                  rd_cnt, valid_seen, bus.busy);
      end
      clear_rec();
      launch(4'd0, 5'd2);
      wait_idle(0, n);
      fb = -1;
      for (int i = 0; i < 2; i++)
         if (fb < 0 && (i >= rx_q.size() || rx_q[i] !== exp_word(4'd0, 2, i))) fb = i;
      checks++;
      if (timeout || fb >= 0 || rx_q.size() != 2 || bus.words_sent !== 5'd2 || done_cnt !== 1) begin
         errors++;
         $display("FAIL midrst_rerun: %0d words first bad %0d ws=%0d done=%0d timeout=%0d, required 2 words A0,A1 ws=2 done=1",
                  rx_q.size(), fb, bus.words_sent, done_cnt, timeout);
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 8'(8'hA0 + i);
      bus.start     = 1'b0;
      bus.base_addr = '0;
      bus.burst_len = '0;
      bus.out_ready = 1'b0;
      test_reset();
      test_basic();
      test_wrap_clamp();
      test_backpressure();
      test_zero_len();
      test_busy_start();
      test_reset_mid_burst();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
